// File: rtl/parking_gate_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parking_gate_arbiter_pkg
//  Description : Shared definitions for the parking gate arbiter: FSM state
//                encoding, requester indices, default gate-open time and the
//                round-robin pick helper.
//  Revision    : 1.0  initial release
// ============================================================================
package parking_gate_arbiter_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_COMMIT = 2'd1;
    localparam state_t c_ST_SETTLE = 2'd2;

    // Requester indices: entries occupy the low half, exits the high half,
    // so bit 1 of an index is the "is exit" flag and bit 0 is the lane.
    localparam logic [1:0] c_REQ_ENTRY0 = 2'd0;
    localparam logic [1:0] c_REQ_ENTRY1 = 2'd1;
    localparam logic [1:0] c_REQ_EXIT0  = 2'd2;
    localparam logic [1:0] c_REQ_EXIT1  = 2'd3;

    localparam int c_DEFAULT_GATE_OPEN_CYCLES = 50;

    // Round-robin pick: returns {found, index}. The scan runs from the
    // farthest offset down to offset 0 so that the requester nearest to
    // ptr is the one left in 'pick' at the end.
    function automatic logic [2:0] rr_pick(input logic [3:0] elig,
                                           input logic [1:0] ptr);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = {1'b0, ptr};
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (elig[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parking_gate_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : parking_gate_arbiter_if
//  Description : Lane/counter side bundle of the parking gate arbiter.
//                master : lane sensors + counter (drive requests and flags)
//                slave  : the arbiter (drives events, grants, gates)
//  Ports       : entry_req/entry_is_uni/exit_req/exit_is_uni [1:0],
//                uni_is_vacated_space, is_vacated_space,
//                car_entered, is_uni_car_entered, car_exited,
//                is_uni_car_exited, entry_grant/entry_reject/exit_grant [1:0],
//                entry_gate_open/exit_gate_open [1:0]
//  Revision    : 1.0  initial release
// ============================================================================
interface parking_gate_arbiter_if;
    logic [1:0] entry_req;
    logic [1:0] entry_is_uni;
    logic [1:0] exit_req;
    logic [1:0] exit_is_uni;
    logic       uni_is_vacated_space;
    logic       is_vacated_space;
    logic       car_entered;
    logic       is_uni_car_entered;
    logic       car_exited;
    logic       is_uni_car_exited;
    logic [1:0] entry_grant;
    logic [1:0] entry_reject;
    logic [1:0] exit_grant;
    logic [1:0] entry_gate_open;
    logic [1:0] exit_gate_open;

    modport master (
        output entry_req, entry_is_uni, exit_req, exit_is_uni,
               uni_is_vacated_space, is_vacated_space,
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
               entry_grant, entry_reject, exit_grant,
               entry_gate_open, exit_gate_open
    );

    modport slave (
        input  entry_req, entry_is_uni, exit_req, exit_is_uni,
               uni_is_vacated_space, is_vacated_space,
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
               entry_grant, entry_reject, exit_grant,
               entry_gate_open, exit_gate_open
    );
endinterface
`default_nettype wire

// File: rtl/parking_gate_arbiter_timer.sv
`default_nettype none
// ============================================================================
//  Module      : parking_gate_timer
//  Description : Barrier timer for one lane. A load sets the count to
//                GATE_OPEN_CYCLES; it then counts down once per cycle to 0.
//                The gate is open whenever the count is nonzero.
//  Ports       : clk, reset (async, active-high), load, gate_open
//  Revision    : 1.0  initial release
// ============================================================================
module parking_gate_timer #(
    parameter int GATE_OPEN_CYCLES = 50,   // >= 1
    parameter int TIMER_W          = 8     // 2**TIMER_W > GATE_OPEN_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic gate_open
);
    localparam logic [TIMER_W-1:0] c_LOAD_VALUE = TIMER_W'(GATE_OPEN_CYCLES);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_LOAD_VALUE;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign gate_open = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : parking_gate_arbiter
//  Description : Arbitrates two entry and two exit lanes onto the parking
//                counter's single event interface. One decision per
//                IDLE -> COMMIT -> SETTLE round, so counter events are at
//                least two cycles apart and never coincide. Entries are
//                rejected when the requested class has no space. Each lane
//                owns a barrier timer that opens the gate on a grant.
//  Ports       : clk, reset (async, active-high),
//                bus (parking_gate_arbiter_if.slave)
//  Revision    : 1.0  initial release
// ============================================================================
module parking_gate_arbiter
    import parking_gate_arbiter_pkg::*;
#(
    parameter int GATE_OPEN_CYCLES = c_DEFAULT_GATE_OPEN_CYCLES,
    parameter int TIMER_W          = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    parking_gate_arbiter_if.slave bus
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_rr_ptr;
    logic [1:0] r_winner;
    logic       r_win_uni;
    logic       r_accept;

    logic [3:0] w_req;
    logic [3:0] w_cls;
    logic [3:0] w_gate_open;
    logic [3:0] w_eligible;
    logic [3:0] w_load;
    logic [2:0] w_pick;
    logic       w_found;
    logic [1:0] w_winner;
    logic       w_win_uni;
    logic       w_space;
    logic       w_accept;

    // Requester vectors indexed entry0, entry1, exit0, exit1
    assign w_req = {bus.exit_req, bus.entry_req};
    assign w_cls = {bus.exit_is_uni, bus.entry_is_uni};

    // Lanes with an open gate are ignored, not queued
    assign w_eligible = (r_state == c_ST_IDLE) ? (w_req & ~w_gate_open) : 4'b0000;
    assign w_pick     = rr_pick(w_eligible, r_rr_ptr);
    assign w_found    = w_pick[2];
    assign w_winner   = w_pick[1:0];

    // Space decision is taken in the selection cycle; exits always pass
    assign w_win_uni = w_cls[w_winner];
    assign w_space   = w_win_uni ? bus.uni_is_vacated_space : bus.is_vacated_space;
    assign w_accept  = w_winner[1] | w_space;

    // Loading at the selection edge opens the gate in the COMMIT cycle,
    // aligned with the grant pulse.
    generate
        for (genvar g = 0; g < 4; g++) begin : g_lane
            assign w_load[g] = w_found & w_accept & (w_winner == 2'(g));

            parking_gate_timer #(
                .GATE_OPEN_CYCLES (GATE_OPEN_CYCLES),
                .TIMER_W          (TIMER_W)
            ) u_timer (
                .clk       (clk),
                .reset     (reset),
                .load      (w_load[g]),
                .gate_open (w_gate_open[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE:   w_next_state = w_found ? c_ST_COMMIT : c_ST_IDLE;
            c_ST_COMMIT: w_next_state = c_ST_SETTLE;
            c_ST_SETTLE: w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Winner capture and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= 2'd0;
            r_winner  <= 2'd0;
            r_win_uni <= 1'b0;
            r_accept  <= 1'b0;
        end else if (w_found) begin
            r_rr_ptr  <= w_winner + 2'd1;
            r_winner  <= w_winner;
            r_win_uni <= w_win_uni;
            r_accept  <= w_accept;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. All pulses come only from COMMIT, so a reset clears
    // them in the same cycle it is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        bus.car_entered        = 1'b0;
        bus.is_uni_car_entered = 1'b0;
        bus.car_exited         = 1'b0;
        bus.is_uni_car_exited  = 1'b0;
        bus.entry_grant        = 2'b00;
        bus.entry_reject       = 2'b00;
        bus.exit_grant         = 2'b00;
        if (r_state == c_ST_COMMIT) begin
            if (r_winner[1]) begin
                bus.car_exited               = 1'b1;
                bus.is_uni_car_exited        = r_win_uni;
                bus.exit_grant[r_winner[0]]  = 1'b1;
            end else if (r_accept) begin
                bus.car_entered              = 1'b1;
                bus.is_uni_car_entered       = r_win_uni;
                bus.entry_grant[r_winner[0]] = 1'b1;
            end else begin
                bus.entry_reject[r_winner[0]] = 1'b1;
            end
        end
    end

    assign bus.entry_gate_open = w_gate_open[1:0];
    assign bus.exit_gate_open  = w_gate_open[3:2];

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parking_gate_arbiter
//  Description : Self-checking bench for parking_gate_arbiter. A cycle model
//                (decision lockout, pending event, per-lane open counters)
//                is compared against every output on every cycle, and
//                directed scenarios pin literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_parking_gate_arbiter;

    localparam int G = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;

    parking_gate_arbiter_if bus ();

    parking_gate_arbiter #(
        .GATE_OPEN_CYCLES (G),
        .TIMER_W          (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] out_vec();
        return {bus.car_entered, bus.is_uni_car_entered,
                bus.car_exited, bus.is_uni_car_exited,
                bus.entry_grant, bus.entry_reject, bus.exit_grant,
                bus.entry_gate_open, bus.exit_gate_open};
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: a decision may be made only when no decision was
    // made in the previous two cycles; the decision's event appears the
    // following cycle; a granted lane's gate stays open G cycles from then.
    // ------------------------------------------------------------------
    int m_gate [4];
    int m_lock;
    int m_ptr;
    bit m_pv;
    int m_pl;
    bit m_pu;
    bit m_pa;

    always @(negedge clk) begin
        logic [13:0] e;
        logic [1:0]  eg, er, xg, eo, xo;
        logic [3:0]  req, cls;
        bit          nv, nu, na;
        int          nl, idx;
        logic [13:0] a;
        a  = out_vec();
        eg = 0; er = 0; xg = 0; eo = 0; xo = 0;
        e  = 0;
        if (reset) begin
            m_lock = 0; m_ptr = 0; m_pv = 0; m_pl = 0; m_pu = 0; m_pa = 0;
            for (int k = 0; k < 4; k++) m_gate[k] = 0;
            chk("reset_outputs", int'(a), 0);
        end else begin
            // expected outputs of this cycle
            if (m_pv && m_pl < 2 && m_pa)  eg[m_pl]     = 1'b1;
            if (m_pv && m_pl < 2 && !m_pa) er[m_pl]     = 1'b1;
            if (m_pv && m_pl >= 2)         xg[m_pl - 2] = 1'b1;
            for (int k = 0; k < 2; k++) begin
                eo[k] = (m_gate[k] > 0);
                xo[k] = (m_gate[k + 2] > 0);
            end
            e = {(eg != 0), (eg != 0) & m_pu, (xg != 0), (xg != 0) & m_pu,
                 eg, er, xg, eo, xo};
            chk("cycle_outputs", int'(a), int'(e));
            chk("no_coincident_events", int'(bus.car_entered & bus.car_exited), 0);
            chk("single_pulse", int'($countones({bus.entry_grant, bus.entry_reject,
                                                 bus.exit_grant}) > 1), 0);

            // advance to next cycle
            req = {bus.exit_req, bus.entry_req};
            cls = {bus.exit_is_uni, bus.entry_is_uni};
            nv = 0; nl = 0; nu = 0; na = 0;
            if (m_lock == 0) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (!nv && req[idx] && m_gate[idx] == 0) begin
                        nv = 1; nl = idx;
                    end
                end
            end
            if (nv) begin
                nu    = cls[nl];
                na    = (nl >= 2) ? 1'b1 : (nu ? bus.uni_is_vacated_space
                                               : bus.is_vacated_space);
                m_ptr = (nl + 1) % 4;
                m_lock = 2;
            end else if (m_lock > 0) begin
                m_lock--;
            end
            for (int k = 0; k < 4; k++) begin
                if (nv && na && nl == k) m_gate[k] = G;
                else if (m_gate[k] > 0)  m_gate[k]--;
            end
            m_pv = nv; m_pl = nl; m_pu = nu; m_pa = na;
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.entry_req = 0; bus.entry_is_uni = 0;
        bus.exit_req  = 0; bus.exit_is_uni  = 0;
        bus.uni_is_vacated_space = 1'b1;
        bus.is_vacated_space     = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // T1: normal entry on lane 0; gate open cycles 1..G
        tick(); bus.entry_req = 2'b01;                      // cycle 0
        mid();  chk("t1_c0_no_event", int'(bus.car_entered), 0);
        tick(); mid();                                      // cycle 1
        chk("t1_entry_grant",  int'(bus.entry_grant), 1);
        chk("t1_car_entered",  int'(bus.car_entered), 1);
        chk("t1_uni_flag",     int'(bus.is_uni_car_entered), 0);
        chk("t1_gate_c1",      int'(bus.entry_gate_open), 1);
        tick(); bus.entry_req = 2'b00; mid();               // cycle 2
        chk("t1_gate_c2", int'(bus.entry_gate_open), 1);
        for (int c = 3; c <= 4; c++) begin
            tick(); mid();
            chk("t1_gate_open", int'(bus.entry_gate_open), 1);
        end
        tick(); mid();                                      // cycle 5
        chk("t1_gate_closed_c5", int'(bus.entry_gate_open), 0);

        // T2: entry0, entry1, exit0(uni) together -> served in index order
        do_reset();
        tick(); bus.entry_req = 2'b11; bus.exit_req = 2'b01; bus.exit_is_uni = 2'b01;
        tick(); mid();                                      // cycle 1
        chk("t2_first_entry0", int'(bus.entry_grant), 1);
        tick(); bus.entry_req = 2'b10;                      // cycle 2
        tick(); tick(); mid();                              // cycle 4
        chk("t2_second_entry1", int'(bus.entry_grant), 2);
        chk("t2_second_event",  int'(bus.car_entered), 1);
        tick(); bus.entry_req = 2'b00;                      // cycle 5
        tick(); tick(); mid();                              // cycle 7
        chk("t2_third_exit0",  int'(bus.exit_grant), 1);
        chk("t2_car_exited",   int'(bus.car_exited), 1);
        chk("t2_uni_exited",   int'(bus.is_uni_car_exited), 1);
        tick(); bus.exit_req = 2'b00;                       // cycle 8
        tick(); tick();

        // T3: uni entry on lane 1 with no uni space -> reject, then exit0
        do_reset();
        bus.uni_is_vacated_space = 1'b0;
        tick(); bus.entry_req = 2'b10; bus.entry_is_uni = 2'b10; bus.exit_req = 2'b01;
        tick(); mid();                                      // cycle 1
        chk("t3_reject_lane1", int'(bus.entry_reject), 2);
        chk("t3_no_entry_evt", int'(bus.car_entered), 0);
        chk("t3_gate_shut",    int'(bus.entry_gate_open), 0);
        tick(); bus.entry_req = 2'b00;                      // cycle 2
        tick(); tick(); mid();                              // cycle 4
        chk("t3_exit0_grant", int'(bus.exit_grant), 1);
        chk("t3_exit_nonuni", int'(bus.is_uni_car_exited), 0);
        tick(); bus.exit_req = 2'b00;
        tick(); tick();

        // T4: reset while entry0 gate is open
        do_reset();
        tick(); bus.entry_req = 2'b01;                      // cycle 0
        tick(); mid();                                      // cycle 1
        chk("t4_gate_before_rst", int'(bus.entry_gate_open), 1);
        tick(); bus.entry_req = 2'b00; reset = 1'b1; mid(); // cycle 2
        chk("t4_all_zero_in_rst", int'(out_vec()), 0);
        tick();                                             // cycle 3
        tick(); reset = 1'b0; bus.entry_req = 2'b10; bus.exit_req = 2'b10;
        mid();                                              // cycle 4
        chk("t4_idle_after_rst", int'(out_vec()), 0);
        tick(); mid();                                      // cycle 5
        chk("t4_lowest_first", int'(bus.entry_grant), 2);
        tick(); bus.entry_req = 2'b00;                      // cycle 6
        tick(); tick(); mid();                              // cycle 8
        chk("t4_then_exit1", int'(bus.exit_grant), 2);
        tick(); bus.exit_req = 2'b00;
        tick(); tick();

        // T5: entry0 and exit1 held continuously -> alternating grants
        do_reset();
        tick(); bus.entry_req = 2'b01; bus.exit_req = 2'b10;   // cycle 0
        for (int c = 1; c <= 13; c++) begin
            tick(); mid();
            if (c % 3 == 1) begin
                if (((c - 1) / 3) % 2 == 0)
                    chk("t5_alt_entry0", int'({bus.entry_grant, bus.exit_grant}), 4);
                else
                    chk("t5_alt_exit1",  int'({bus.entry_grant, bus.exit_grant}), 2);
            end
        end
        bus.entry_req = 2'b00; bus.exit_req = 2'b00;
        repeat (8) tick();

        // T6: entry0 held while its gate is open -> no regrant until closed
        do_reset();
        tick(); bus.entry_req = 2'b01;                      // cycle 0
        tick(); mid();                                      // cycle 1
        chk("t6_first_grant", int'(bus.entry_grant), 1);
        for (int c = 2; c <= 5; c++) begin
            tick(); mid();
            chk("t6_held_no_grant", int'(bus.entry_grant), 0);
        end
        tick(); mid();                                      // cycle 6
        chk("t6_regrant_c6", int'(bus.entry_grant), 1);
        tick(); bus.entry_req = 2'b00;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
